hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Central pipeline controller for the 5-stage MIPS core. It sequences the IF/ID/EX front end against data hazards, taken branches and the multi-cycle multiplier.
- Generates PC/IF-ID write enables, the flush and bubble controls, and the EX-stage forwarding selects (ALUSrcA/ALUSrcB).
- Drives the Stall signal exported to the top level. Keeps a saturating stall-cycle counter for the performance debug port.

Parameters:
- MUL_LATENCY, 4, cycles a multiply occupies EX; legal range 2..15.
- REG_AW, 5, register address width.
- CNT_W, 16, width of StallCount.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ID_Rs  in  REG_AW  source register of the instruction in ID.
- ID_Rt  in  REG_AW  second source register of the instruction in ID.
- ID_UsesRs  in  1  ID instruction reads Rs.
- ID_UsesRt  in  1  ID instruction reads Rt.
- EX_Rs  in  REG_AW  Rs of the instruction in EX.
- EX_Rt  in  REG_AW  Rt of the instruction in EX.
- EX_Rd  in  REG_AW  selected destination (rDestSelected) in EX.
- EX_RegWrite  in  1  EX instruction writes the register file.
- EX_MemRead  in  1  EX instruction is a load.
- EX_MulStart  in  1  EX instruction is a multiply; level-true for as long as it sits in EX.
- EX_BranchTaken  in  1  branch/jump resolved taken in EX.
- MEM_Rd  in  REG_AW  destination register in MEM.
- MEM_RegWrite  in  1  MEM instruction writes the register file.
- WB_Rd  in  REG_AW  destination register in WB.
- WB_RegWrite  in  1  WB instruction writes the register file.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register enable.
- IFIDFlush  out  1  zero the IF/ID register.
- IDEXBubble  out  1  load a NOP into ID/EX.
- EXHold  out  1  freeze EX/MEM inputs; ID/EX holds.
- Stall  out  1  PCWrite=0 and IFIDWrite=0 this cycle.
- ALUSrcA  out  2  forwarding select for operand A: 00 regfile, 01 MEM, 10 WB.
- ALUSrcB  out  2  forwarding select for operand B, same encoding as ALUSrcA.
- MulBusy  out  1  state is MUL_WAIT.
- MulDone  out  1  final EX cycle of a multiply.
- StallCount  out  CNT_W  saturating count of cycles with Stall=1.

Behaviour:
- Reset (async): state=RUN, mul counter=0, StallCount=0. Comb outputs then take their RUN values with no hazard: PCWrite=1, IFIDWrite=1, all other controls 0, selects 00.
- Register 0 never creates a hazard and is never forwarded.
- Forwarding (comb, every cycle):
  - ALUSrcA=01 if MEM_RegWrite && MEM_Rd!=0 && MEM_Rd==EX_Rs.
  - Otherwise ALUSrcA=10 if WB_RegWrite && WB_Rd!=0 && WB_Rd==EX_Rs.
  - Otherwise ALUSrcA=00.
  - ALUSrcB follows the same rules with EX_Rt. MEM has priority over WB.
- LoadUse (comb): EX_MemRead && EX_Rd!=0 && ((ID_UsesRs && ID_Rs==EX_Rd) || (ID_UsesRt && ID_Rt==EX_Rd)).
- FSM states: RUN, MUL_WAIT, MUL_LAST.
- RUN:
  - If EX_BranchTaken: IFIDFlush=1, IDEXBubble=1, no stall. LoadUse is ignored because the ID instruction is squashed.
  - Else if EX_MulStart: Stall=1, EXHold=1, IDEXBubble=0, MulBusy=0. Counter loads MUL_LATENCY-2. Next state is MUL_WAIT if MUL_LATENCY>2, otherwise MUL_LAST.
  - Else if LoadUse: Stall=1, IDEXBubble=1, for one cycle. No state change; the bubble clears EX_MemRead.
- MUL_WAIT:
  - Stall=1, EXHold=1, MulBusy=1.
  - EX_BranchTaken and LoadUse are ignored.
  - Counter decrements each cycle. When counter==1, next state is MUL_LAST.
- MUL_LAST:
  - Stall=0, EXHold=0, MulDone=1.
  - EX_MulStart is ignored, because the same multiply is still in EX.
  - LoadUse is evaluated as in RUN. EX holds a multiply, so it cannot be a load; LoadUse is therefore 0.
  - Next state is RUN.
- Stall timing: Stall is high for exactly MUL_LATENCY-1 consecutive cycles per multiply, including the start cycle. MulDone is high in the following cycle.
- Always: PCWrite=IFIDWrite=!Stall.
- StallCount increments on each rising edge where Stall=1 and holds at 2^CNT_W-1.
- Reset asserted mid-multiply: the FSM returns to RUN immediately and the counter clears. No MulDone is produced.

Test Plan:
- Reset held 3 cycles, then released with all inputs 0 -> PCWrite=1, IFIDWrite=1, Stall=0, ALUSrcA=ALUSrcB=00, StallCount=0.
- MEM_Rd=8 with MEM_RegWrite=1, WB_Rd=8 with WB_RegWrite=1, EX_Rs=8, EX_Rt=9 -> ALUSrcA=01, ALUSrcB=00. Change to WB_Rd=9 -> ALUSrcB=10. Set Rd=0 on both stages -> ALUSrcA=ALUSrcB=00.
- EX_MemRead=1, EX_Rd=5, ID_Rt=5, ID_UsesRt=1 -> exactly 1 cycle of Stall=1 and IDEXBubble=1. Add EX_BranchTaken=1 in the same cycle -> Stall=0, IFIDFlush=1.
- EX_MulStart held high, MUL_LATENCY=4 -> Stall=1 for 3 cycles with MulBusy=1 in cycles 2-3 and MulDone=1 in cycle 4. No re-trigger while EX_MulStart stays high. StallCount=3.
- Reset asserted during the second MUL_WAIT cycle -> Stall=0 and state=RUN asynchronously, StallCount=0, no MulDone.
- Force 65540 stall cycles (repeated multiplies) -> StallCount saturates at 65535.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller for the 5-stage MIPS core: forwarding selects,
// load-use and branch handling, multi-cycle multiply sequencing and a stall counter.
module hazard_stall_controller #(
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic [REG_AW-1:0] EX_Rs,
    input  logic [REG_AW-1:0] EX_Rt,
    input  logic [REG_AW-1:0] EX_Rd,
    input  logic              EX_RegWrite,
    input  logic              EX_MemRead,
    input  logic              EX_MulStart,
    input  logic              EX_BranchTaken,
    input  logic [REG_AW-1:0] MEM_Rd,
    input  logic              MEM_RegWrite,
    input  logic [REG_AW-1:0] WB_Rd,
    input  logic              WB_RegWrite,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              IFIDFlush,
    output logic              IDEXBubble,
    output logic              EXHold,
    output logic              Stall,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic              MulBusy,
    output logic              MulDone,
    output logic [CNT_W-1:0]  StallCount
);

    localparam int unsigned MCW = 4;
    localparam logic [1:0] SelRegFile = 2'b00;
    localparam logic [1:0] SelMem     = 2'b01;
    localparam logic [1:0] SelWb      = 2'b10;
    localparam logic [MCW-1:0] MulLoad = MCW'(MUL_LATENCY - 2);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        MUL_LAST = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [MCW-1:0] mul_cnt_q, mul_cnt_d;
    logic           load_use;
    logic           mem_fwd_ok, wb_fwd_ok;

    // EX_RegWrite is carried for completeness; the load flag alone marks a load destination.
    logic unused_ex_regwrite;
    assign unused_ex_regwrite = EX_RegWrite;

    assign mem_fwd_ok = MEM_RegWrite && (MEM_Rd != '0);
    assign wb_fwd_ok  = WB_RegWrite && (WB_Rd != '0);

    always_comb begin
        ALUSrcA = SelRegFile;
        if (mem_fwd_ok && (MEM_Rd == EX_Rs)) begin
            ALUSrcA = SelMem;
        end else if (wb_fwd_ok && (WB_Rd == EX_Rs)) begin
            ALUSrcA = SelWb;
        end
    end

    always_comb begin
        ALUSrcB = SelRegFile;
        if (mem_fwd_ok && (MEM_Rd == EX_Rt)) begin
            ALUSrcB = SelMem;
        end else if (wb_fwd_ok && (WB_Rd == EX_Rt)) begin
            ALUSrcB = SelWb;
        end
    end

    assign load_use = EX_MemRead && (EX_Rd != '0) &&
                      ((ID_UsesRs && (ID_Rs == EX_Rd)) || (ID_UsesRt && (ID_Rt == EX_Rd)));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Controls are forced to their idle RUN values while reset is held.
    always_comb begin
        state_d    = state_q;
        mul_cnt_d  = mul_cnt_q;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        EXHold     = 1'b0;
        Stall      = 1'b0;
        MulBusy    = 1'b0;
        MulDone    = 1'b0;
        if (!Reset) begin
            case (state_q)
                RUN: begin
                    if (EX_BranchTaken) begin
                        IFIDFlush  = 1'b1;
                        IDEXBubble = 1'b1;
                    end else if (EX_MulStart) begin
                        Stall     = 1'b1;
                        EXHold    = 1'b1;
                        mul_cnt_d = MulLoad;
                        state_d   = (MUL_LATENCY > 2) ? MUL_WAIT : MUL_LAST;
                    end else if (load_use) begin
                        Stall      = 1'b1;
                        IDEXBubble = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    Stall     = 1'b1;
                    EXHold    = 1'b1;
                    MulBusy   = 1'b1;
                    mul_cnt_d = mul_cnt_q - MCW'(1);
                    if (mul_cnt_q == MCW'(1)) begin
                        state_d = MUL_LAST;
                    end
                end
                MUL_LAST: begin
                    MulDone = 1'b1;
                    state_d = RUN;
                    if (EX_BranchTaken) begin
                        IFIDFlush  = 1'b1;
                        IDEXBubble = 1'b1;
                    end else if (load_use) begin
                        Stall      = 1'b1;
                        IDEXBubble = 1'b1;
                    end
                end
                default: begin
                    state_d   = RUN;
                    mul_cnt_d = '0;
                end
            endcase
        end
    end

    assign PCWrite   = !Stall;
    assign IFIDWrite = !Stall;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            StallCount <= '0;
        end else if (Stall && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller with hand-computed expectations.
module tb_hazard_stall_controller;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [4:0]  ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_Rd, MEM_Rd, WB_Rd;
    logic        ID_UsesRs, ID_UsesRt, EX_RegWrite, EX_MemRead, EX_MulStart, EX_BranchTaken;
    logic        MEM_RegWrite, WB_RegWrite;
    logic        PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, EXHold, Stall, MulBusy, MulDone;
    logic [1:0]  ALUSrcA, ALUSrcB;
    logic [15:0] StallCount;

    int n_vec = 0;
    int n_err = 0;

    hazard_stall_controller #(
        .MUL_LATENCY(4),
        .REG_AW     (5),
        .CNT_W      (16)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .ID_Rs         (ID_Rs),
        .ID_Rt         (ID_Rt),
        .ID_UsesRs     (ID_UsesRs),
        .ID_UsesRt     (ID_UsesRt),
        .EX_Rs         (EX_Rs),
        .EX_Rt         (EX_Rt),
        .EX_Rd         (EX_Rd),
        .EX_RegWrite   (EX_RegWrite),
        .EX_MemRead    (EX_MemRead),
        .EX_MulStart   (EX_MulStart),
        .EX_BranchTaken(EX_BranchTaken),
        .MEM_Rd        (MEM_Rd),
        .MEM_RegWrite  (MEM_RegWrite),
        .WB_Rd         (WB_Rd),
        .WB_RegWrite   (WB_RegWrite),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IFIDFlush     (IFIDFlush),
        .IDEXBubble    (IDEXBubble),
        .EXHold        (EXHold),
        .Stall         (Stall),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .MulBusy       (MulBusy),
        .MulDone       (MulDone),
        .StallCount    (StallCount)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        n_vec++;
        if (obs !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, expected);
        end
    endtask

    task automatic clear_inputs();
        ID_Rs = '0; ID_Rt = '0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
        EX_Rs = '0; EX_Rt = '0; EX_Rd = '0;
        EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_MulStart = 1'b0; EX_BranchTaken = 1'b0;
        MEM_Rd = '0; MEM_RegWrite = 1'b0; WB_Rd = '0; WB_RegWrite = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs are then driven there.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        clear_inputs();
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        #1;
        check("rst_pcwrite", 32'(PCWrite), 1);
        check("rst_ifidwrite", 32'(IFIDWrite), 1);
        check("rst_stall", 32'(Stall), 0);
        check("rst_srca", 32'(ALUSrcA), 0);
        check("rst_srcb", 32'(ALUSrcB), 0);
        check("rst_count", 32'(StallCount), 0);

        // Forwarding priority and r0 suppression
        MEM_Rd = 5'd8; MEM_RegWrite = 1'b1; WB_Rd = 5'd8; WB_RegWrite = 1'b1;
        EX_Rs = 5'd8; EX_Rt = 5'd9;
        #1;
        check("fwd_a_mem", 32'(ALUSrcA), 1);
        check("fwd_b_none", 32'(ALUSrcB), 0);
        WB_Rd = 5'd9;
        #1;
        check("fwd_a_mem2", 32'(ALUSrcA), 1);
        check("fwd_b_wb", 32'(ALUSrcB), 2);
        MEM_RegWrite = 1'b0; WB_Rd = 5'd8;
        #1;
        check("fwd_a_wb", 32'(ALUSrcA), 2);
        MEM_RegWrite = 1'b1; MEM_Rd = 5'd0; WB_Rd = 5'd0; EX_Rs = 5'd0; EX_Rt = 5'd0;
        #1;
        check("fwd_a_r0", 32'(ALUSrcA), 0);
        check("fwd_b_r0", 32'(ALUSrcB), 0);
        clear_inputs();

        // Load-use
        step();
        EX_MemRead = 1'b1; EX_Rd = 5'd5; ID_Rt = 5'd5; ID_UsesRt = 1'b0;
        #1;
        check("lu_unused_rt", 32'(Stall), 0);
        ID_UsesRt = 1'b1;
        #1;
        check("lu_stall", 32'(Stall), 1);
        check("lu_bubble", 32'(IDEXBubble), 1);
        check("lu_pcwrite", 32'(PCWrite), 0);
        step();
        EX_MemRead = 1'b0;
        #1;
        check("lu_one_cycle", 32'(Stall), 0);
        check("lu_count", 32'(StallCount), 1);
        EX_MemRead = 1'b1; EX_BranchTaken = 1'b1;
        #1;
        check("br_stall", 32'(Stall), 0);
        check("br_flush", 32'(IFIDFlush), 1);
        check("br_bubble", 32'(IDEXBubble), 1);
        EX_BranchTaken = 1'b0; EX_Rd = 5'd0; ID_Rt = 5'd0;
        #1;
        check("lu_r0", 32'(Stall), 0);
        step();
        check("br_count", 32'(StallCount), 1);
        clear_inputs();

        // Clear the counter, then a 4-cycle multiply
        Reset = 1'b1;
        #1;
        check("rst2_count", 32'(StallCount), 0);
        step();
        Reset = 1'b0;
        EX_MulStart = 1'b1;
        #1;
        check("mul_c1_stall", 32'(Stall), 1);
        check("mul_c1_hold", 32'(EXHold), 1);
        check("mul_c1_busy", 32'(MulBusy), 0);
        check("mul_c1_bubble", 32'(IDEXBubble), 0);
        for (int c = 2; c <= 3; c++) begin
            step();
            check($sformatf("mul_c%0d_stall", c), 32'(Stall), 1);
            check($sformatf("mul_c%0d_busy", c), 32'(MulBusy), 1);
            check($sformatf("mul_c%0d_done", c), 32'(MulDone), 0);
        end
        step();
        check("mul_c4_stall", 32'(Stall), 0);
        check("mul_c4_hold", 32'(EXHold), 0);
        check("mul_c4_done", 32'(MulDone), 1);
        check("mul_c4_pcwrite", 32'(PCWrite), 1);
        check("mul_count", 32'(StallCount), 3);
        step();
        EX_MulStart = 1'b0;
        #1;
        check("mul_c5_done", 32'(MulDone), 0);
        check("mul_c5_stall", 32'(Stall), 0);

        // Reset in the second MUL_WAIT cycle
        step();
        EX_MulStart = 1'b1;
        step();
        step();
        check("mrst_busy_before", 32'(MulBusy), 1);
        #2 Reset = 1'b1;
        #1;
        check("mrst_stall", 32'(Stall), 0);
        check("mrst_busy", 32'(MulBusy), 0);
        check("mrst_done", 32'(MulDone), 0);
        check("mrst_count", 32'(StallCount), 0);
        EX_MulStart = 1'b0;
        step();
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("mrst_nodone%0d", c), 32'(MulDone), 0);
        end

        // Saturation: a persistent load-use stalls on every edge
        EX_MemRead = 1'b1; EX_Rd = 5'd7; ID_Rs = 5'd7; ID_UsesRs = 1'b1;
        repeat (65534) @(posedge Clock);
        #1;
        check("sat_65534", 32'(StallCount), 65534);
        repeat (1) @(posedge Clock);
        #1;
        check("sat_65535", 32'(StallCount), 65535);
        repeat (5) @(posedge Clock);
        #1;
        check("sat_hold", 32'(StallCount), 65535);
        check("sat_stall", 32'(Stall), 1);
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
